// File: rtl/cic_dec_ctrl.sv
// CIC decimator controller: holds the decimation ratio, runs flush/warm-up sequencing and emits the comb strobe.
// Defining CIC_CTRL_GAIN_EN adds a registered gain_shift (bit growth) output.
module cic_dec_ctrl #(
  parameter int N_ORDER   = 3,
  parameter int DELAY     = 4,
  parameter int R_MAX     = 16,
  parameter int R_DEF     = 4,
  parameter int RW        = 5,
  parameter int FLUSH_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [RW-1:0] cfg_ratio,
  input  logic          enable,
  input  logic          in_valid,
  output logic          cfg_ack,
  output logic          err_ratio,
  output logic          clear_o,
  output logic          dec_stb,
  output logic          out_valid,
  output logic          busy,
  output logic [RW-1:0] ratio_q,
  output logic [1:0]    state_o
`ifdef CIC_CTRL_GAIN_EN
  ,
  output logic [5:0]    gain_shift
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_WARMUP = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam int WARM_N = N_ORDER * DELAY;
  localparam int FW     = $clog2(FLUSH_CYC + 1);
  localparam int WW     = $clog2(WARM_N + 1);

  logic [1:0]    state, state_nx;
  logic [RW-1:0] phase;
  logic [FW-1:0] flush_cnt;
  logic [WW-1:0] warm_cnt;
  logic          cfg_legal, restart, counting, wrap;

  assign cfg_legal = cfg_wr && (cfg_ratio >= RW'(2)) && (cfg_ratio <= RW'(R_MAX));
  // A legal ratio change while active re-flushes; enable=0 still wins the transition.
  assign restart   = enable && cfg_legal && (state != S_IDLE);
  assign counting  = (state == S_WARMUP) || (state == S_RUN);
  assign wrap      = counting && in_valid && (phase == ratio_q - RW'(1));

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = S_IDLE;
    end else if (restart) begin
      state_nx = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:   state_nx = S_FLUSH;
        S_FLUSH:  if (flush_cnt == FW'(FLUSH_CYC - 1)) state_nx = S_WARMUP;
        S_WARMUP: if (dec_stb && (warm_cnt == WW'(WARM_N - 1))) state_nx = S_RUN;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ratio_q   <= RW'(R_DEF);
      cfg_ack   <= 1'b0;
      err_ratio <= 1'b0;
      dec_stb   <= 1'b0;
      phase     <= '0;
      flush_cnt <= '0;
      warm_cnt  <= '0;
    end else begin
      state   <= state_nx;
      cfg_ack <= cfg_legal;
      if (cfg_legal) ratio_q <= cfg_ratio;
      if (cfg_wr && !cfg_legal) err_ratio <= 1'b1;

      // An interrupted phase never produces a strobe.
      dec_stb <= wrap && enable && !restart;

      if (!enable || restart || !counting) phase <= '0;
      else if (in_valid) phase <= wrap ? '0 : phase + RW'(1);

      if (state == S_FLUSH && state_nx == S_FLUSH && !restart) flush_cnt <= flush_cnt + FW'(1);
      else flush_cnt <= '0;

      if (state != S_WARMUP || state_nx != S_WARMUP) warm_cnt <= '0;
      else if (dec_stb) warm_cnt <= warm_cnt + WW'(1);
    end
  end

  assign state_o   = state;
  assign clear_o   = (state == S_FLUSH);
  assign busy      = (state == S_FLUSH) || (state == S_WARMUP);
  assign out_valid = dec_stb && (state == S_RUN);

`ifdef CIC_CTRL_GAIN_EN
  function automatic logic [5:0] bit_growth(input logic [RW-1:0] r);
    int prod;
    int lg;
    prod = int'(r) * DELAY;
    lg   = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < prod) lg = i + 1;
    end
    return 6'(N_ORDER * lg);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gain_shift <= bit_growth(RW'(R_DEF));
    else     gain_shift <= bit_growth(ratio_q);
  end
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Scoreboard bench for cic_dec_ctrl: a sample-count reference model predicts every cycle's outputs.
module tb_cic_dec_ctrl;
  localparam int N_ORDER   = 3;
  localparam int DELAY     = 4;
  localparam int R_MAX     = 16;
  localparam int R_DEF     = 4;
  localparam int RW        = 5;
  localparam int FLUSH_CYC = 2;
  localparam int WARM_N    = N_ORDER * DELAY;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [RW-1:0] cfg_ratio = '0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          cfg_ack, err_ratio, clear_o, dec_stb, out_valid, busy;
  logic [RW-1:0] ratio_q;
  logic [1:0]    state_o;
  logic [5:0]    gs;

  always #5 clk = ~clk;

`ifdef CIC_CTRL_GAIN_EN
  logic [5:0] gain_shift;
  assign gs = gain_shift;
`else
  assign gs = 6'd0;
`endif

  cic_dec_ctrl #(
    .N_ORDER(N_ORDER), .DELAY(DELAY), .R_MAX(R_MAX), .R_DEF(R_DEF), .RW(RW), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ratio(cfg_ratio), .enable(enable),
    .in_valid(in_valid), .cfg_ack(cfg_ack), .err_ratio(err_ratio), .clear_o(clear_o),
    .dec_stb(dec_stb), .out_valid(out_valid), .busy(busy), .ratio_q(ratio_q), .state_o(state_o)
`ifdef CIC_CTRL_GAIN_EN
    , .gain_shift(gain_shift)
`endif
  );

  // Reference model: mode 0..3, samples since warm-up began, strobes seen in warm-up.
  int m_mode, m_ratio, m_flush_left, m_warm, m_samples, m_gain;
  bit m_ack, m_err, m_stb;

  logic [19:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int growth(input int r);
`ifdef CIC_CTRL_GAIN_EN
    return N_ORDER * $clog2(r * DELAY);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ratio = R_DEF; m_flush_left = 0; m_warm = 0; m_samples = 0;
    m_ack = 0; m_err = 0; m_stb = 0; m_gain = growth(R_DEF);
  endtask

  task automatic model_step();
    bit legal, old_stb;
    int old_ratio;
    legal     = cfg_wr && (int'(cfg_ratio) >= 2) && (int'(cfg_ratio) <= R_MAX);
    old_ratio = m_ratio;
    old_stb   = m_stb;
    m_gain    = growth(old_ratio);
    m_ack     = legal;
    if (cfg_wr && !legal) m_err = 1;
    if (legal) m_ratio = int'(cfg_ratio);
    m_stb = 0;
    if (!enable) begin
      m_mode = 0; m_samples = 0; m_warm = 0;
    end else if (legal && m_mode != 0) begin
      m_mode = 1; m_flush_left = FLUSH_CYC;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_flush_left = FLUSH_CYC; end
        1: begin
          m_flush_left--;
          if (m_flush_left == 0) begin m_mode = 2; m_samples = 0; m_warm = 0; end
        end
        default: begin
          if (in_valid) begin
            m_samples++;
            if (m_samples % old_ratio == 0) m_stb = 1;
          end
          if (m_mode == 2 && old_stb) begin
            m_warm++;
            if (m_warm == WARM_N) m_mode = 3;
          end
        end
      endcase
    end
  endtask

  function automatic logic [19:0] exp_word();
    logic [19:0] w;
    w = {1'b0, 6'(m_gain), 2'(m_mode), (m_mode == 1), (m_mode == 1 || m_mode == 2),
         m_stb, (m_stb && m_mode == 3), m_ack, m_err, 5'(m_ratio)};
    return w;
  endfunction

  function automatic logic [19:0] dut_word();
    return {1'b0, gs, state_o, clear_o, busy, dec_stb, out_valid, cfg_ack, err_ratio, ratio_q};
  endfunction

  // One clock: advance the model over the edge, apply the next inputs, predict the outputs.
  task automatic cyc(input bit en, input bit wr, input int r, input bit iv, input bit rs);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step();
    enable = en; cfg_wr = wr; cfg_ratio = RW'(r); in_valid = iv; rst = rs;
    if (rs) model_reset();
    exp_q.push_back(exp_word());
  endtask

  initial begin : monitor
    logic [19:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = dut_word();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got gain/state/clr/busy/stb/ov/ack/err/ratio=%h required=%h",
                   $time, got, e);
        end
      end
    end
  end

  initial begin : stim
    int dens;
    model_reset();
    repeat (3) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, i[0], 0);
    for (int i = 0; i < 80; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 17, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 8, 1, 0);
    for (int i = 0; i < 200; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 4, 1, 0);
    for (int i = 0; i < 24; i++) cyc(1, 0, 0, 1, 0);
    cyc(0, 1, 6, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 200; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 16, 1, 0);
    for (int i = 0; i < 250; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 5, 1, 0);
    for (int i = 0; i < 100; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 60; i++) cyc(1, 0, 0, 1, 0);

    dens = 100;
    for (int i = 0; i < 16000; i++) begin
      bit en, wr, iv, rs;
      int r;
      if (i % 1000 == 0) dens = $urandom_range(30, 100);
      en = ($urandom_range(0, 1499) != 0);
      wr = ($urandom_range(0, 699) == 0);
      r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(2, R_MAX));
      if (wr && ($urandom_range(0, 3) == 0)) begin
        // Occasionally land the write back-to-back to hit restart-during-flush.
        cyc(en, wr, r, 1, 0);
        r = $urandom_range(2, R_MAX);
      end
      iv = ($urandom_range(0, 99) < dens);
      rs = ($urandom_range(0, 4999) == 0);
      cyc(en, wr, r, iv, rs);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
